// File: rtl/id_pkg.sv
// id_pkg: shared widths and the write-port entry type for the register file write scheduler.
package id_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREG   = 32;
   typedef struct packed {
      logic [ADDR_W-1:0] wreg;
      logic [DATA_W-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: long-latency result buffer; valid/ready push, pop strobe, registered storage.
module wb_fifo
   import id_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      i_clk,
   input  logic      i_rst_n,
   input  logic      push_valid,
   output logic      push_ready,
   input  wb_entry_t push_data,
   input  logic      pop,
   output wb_entry_t head,
   output logic      full,
   output logic      empty
);
   localparam int AW = $clog2(DEPTH);
   wb_entry_t mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic push;
   always_comb begin
      empty      = wr_ptr == rd_ptr;
      full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      push_ready = !full;
      push       = push_valid && !full;
      head       = mem[rd_ptr[AW-1:0]];
   end
   always_ff @(posedge i_clk)
      if (push) mem[wr_ptr[AW-1:0]] <= push_data;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
endmodule

// File: rtl/id_wb_sched.sv
// id_wb_sched: arbitrates the register file write port between WB and buffered long-latency results, with a pending-register scoreboard.
module id_wb_sched
   import id_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_LIM = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_pipe_we,
   input  logic [ADDR_W-1:0] i_pipe_reg,
   input  logic [DATA_W-1:0] i_pipe_data,
   input  logic              i_lu_valid,
   output logic              o_lu_ready,
   input  logic [ADDR_W-1:0] i_lu_reg,
   input  logic [DATA_W-1:0] i_lu_data,
   input  logic              i_issue_valid,
   input  logic [ADDR_W-1:0] i_issue_reg,
   input  logic [ADDR_W-1:0] i_rd_reg1,
   input  logic [ADDR_W-1:0] i_rd_reg2,
   input  logic [ADDR_W-1:0] i_dst_reg,
   output logic              o_stall,
   output logic              o_rf_we,
   output logic [ADDR_W-1:0] o_rf_reg,
   output logic [DATA_W-1:0] o_rf_data
);
   localparam int SW = $clog2(STARVE_LIM + 1);
   wb_entry_t lu_entry, head;
   logic full, empty, pipe_act, pop, starve;
   logic [NREG-1:0] pending, pend_set, pend_clr;
   logic [SW-1:0] starve_cnt;
   assign lu_entry = '{wreg: i_lu_reg, data: i_lu_data};
   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .push_valid (i_lu_valid),
      .push_ready (o_lu_ready),
      .push_data  (lu_entry),
      .pop        (pop),
      .head       (head),
      .full       (full),
      .empty      (empty)
   );
   // r0 writes from WB are dropped, so they never take the port from the FIFO
   always_comb begin
      pipe_act  = i_pipe_we && i_pipe_reg != '0;
      pop       = !pipe_act && !empty;
      starve    = starve_cnt == SW'(STARVE_LIM);
      o_stall   = pending[i_rd_reg1] | pending[i_rd_reg2] | pending[i_dst_reg] | starve;
      o_rf_we   = pipe_act || (pop && head.wreg != '0);
      o_rf_reg  = pipe_act ? i_pipe_reg : pop ? head.wreg : '0;
      o_rf_data = pipe_act ? i_pipe_data : pop ? head.data : '0;
      pend_set  = (i_issue_valid && !o_stall && i_issue_reg != '0) ? NREG'(1) << i_issue_reg : '0;
      pend_clr  = pop ? NREG'(1) << head.wreg : '0;
   end
   // set is OR-ed after clear so a re-issue in the pop cycle keeps the bit
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         pending    <= '0;
         starve_cnt <= '0;
      end else begin
         pending    <= ((pending & ~pend_clr) | pend_set) & ~NREG'(1);
         starve_cnt <= (empty || pop) ? '0 : starve ? starve_cnt : starve_cnt + 1'b1;
      end
   always_ff @(posedge i_clk)
      if (i_rst_n) assert (!(i_pipe_we && pending[i_pipe_reg]))
         else $error("pipe write to pending register r%0d", i_pipe_reg);
   logic unused;
   assign unused = full;
endmodule

// File: tb/tb_id_wb_sched.sv
// tb_id_wb_sched: directed stimulus for id_wb_sched with hand-computed expectations.
module tb_id_wb_sched;
   import id_pkg::*;
   logic              i_clk = 0, i_rst_n = 0;
   logic              i_pipe_we = 0, i_lu_valid = 0, i_issue_valid = 0;
   logic [ADDR_W-1:0] i_pipe_reg = 0, i_lu_reg = 0, i_issue_reg = 0;
   logic [ADDR_W-1:0] i_rd_reg1 = 0, i_rd_reg2 = 0, i_dst_reg = 0;
   logic [DATA_W-1:0] i_pipe_data = 0, i_lu_data = 0;
   logic              o_lu_ready, o_stall, o_rf_we;
   logic [ADDR_W-1:0] o_rf_reg;
   logic [DATA_W-1:0] o_rf_data;
   int n = 0, errs = 0;
   id_wb_sched dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_pipe_we(i_pipe_we), .i_pipe_reg(i_pipe_reg), .i_pipe_data(i_pipe_data),
      .i_lu_valid(i_lu_valid), .o_lu_ready(o_lu_ready), .i_lu_reg(i_lu_reg), .i_lu_data(i_lu_data),
      .i_issue_valid(i_issue_valid), .i_issue_reg(i_issue_reg),
      .i_rd_reg1(i_rd_reg1), .i_rd_reg2(i_rd_reg2), .i_dst_reg(i_dst_reg),
      .o_stall(o_stall), .o_rf_we(o_rf_we), .o_rf_reg(o_rf_reg), .o_rf_data(o_rf_data)
   );
   always #5 i_clk = ~i_clk;
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic settle();
      #2;
   endtask
   task automatic pipe(input logic we, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
      i_pipe_we = we; i_pipe_reg = r; i_pipe_data = d;
   endtask
   task automatic lu(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
      i_lu_valid = v; i_lu_reg = r; i_lu_data = d;
   endtask
   task automatic wb(input string tag, input logic we, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
      chk({tag, "_we"}, 64'(o_rf_we), 64'(we));
      if (we) begin
         chk({tag, "_reg"}, 64'(o_rf_reg), 64'(r));
         chk({tag, "_data"}, 64'(o_rf_data), 64'(d));
      end
   endtask
   initial begin
      #12;
      chk("rst_ready", 64'(o_lu_ready), 1);
      chk("rst_stall", 64'(o_stall), 0);
      chk("rst_we", 64'(o_rf_we), 0);
      chk("rst_reg", 64'(o_rf_reg), 0);
      chk("rst_data", 64'(o_rf_data), 0);
      tick(); i_rst_n = 1;
      tick();
      // 1: scoreboard on r5 and its writeback
      i_issue_valid = 1; i_issue_reg = 5; settle();
      chk("t1_nostall", 64'(o_stall), 0);
      tick(); i_issue_valid = 0; i_rd_reg1 = 5; lu(1, 5, 32'hDEADBEEF); settle();
      chk("t1_stall", 64'(o_stall), 1);
      chk("t1_ready", 64'(o_lu_ready), 1);
      wb("t1_nopass", 0, 0, 0);
      tick(); lu(0, 0, 0); settle();
      wb("t1_wb", 1, 5, 32'hDEADBEEF);
      tick(); settle();
      chk("t1_unstall", 64'(o_stall), 0);
      wb("t1_idle", 0, 0, 0);
      i_rd_reg1 = 0;
      // 2: starvation under a continuously busy pipe
      tick(); pipe(1, 3, 32'h11); lu(1, 7, 32'h22); settle();
      wb("t2_pipe", 1, 3, 32'h11);
      for (int i = 0; i < 4; i++) begin
         tick(); lu(0, 0, 0); settle();
         chk("t2_nostarve", 64'(o_stall), 0);
         wb("t2_pipe_hold", 1, 3, 32'h11);
      end
      tick(); settle();
      chk("t2_starve", 64'(o_stall), 1);
      tick(); pipe(0, 0, 0); settle();
      wb("t2_drain", 1, 7, 32'h22);
      tick(); settle();
      chk("t2_unstall", 64'(o_stall), 0);
      wb("t2_empty", 0, 0, 0);
      // 3: full FIFO backpressure and ordering
      tick(); pipe(1, 3, 32'h11); lu(1, 8, 32'h88); settle();
      chk("t3_ready0", 64'(o_lu_ready), 1);
      tick(); lu(1, 9, 32'h99); settle();
      chk("t3_ready1", 64'(o_lu_ready), 1);
      tick(); lu(1, 10, 32'hAA); settle();
      chk("t3_full", 64'(o_lu_ready), 0);
      tick(); pipe(0, 0, 0); settle();
      chk("t3_full_pop", 64'(o_lu_ready), 0);
      wb("t3_r8", 1, 8, 32'h88);
      tick(); settle();
      chk("t3_accept", 64'(o_lu_ready), 1);
      wb("t3_r9", 1, 9, 32'h99);
      tick(); lu(0, 0, 0); settle();
      wb("t3_r10", 1, 10, 32'hAA);
      // 4: r0 pipe write does not block the FIFO
      tick(); pipe(1, 0, 32'h77); lu(1, 4, 32'h55); settle();
      wb("t4_r0_drop", 0, 0, 0);
      tick(); lu(0, 0, 0); settle();
      wb("t4_r4", 1, 4, 32'h55);
      // 5: re-issue of r6 in its pop cycle keeps it pending
      tick(); pipe(0, 0, 0); i_issue_valid = 1; i_issue_reg = 6;
      tick(); i_issue_valid = 0; lu(1, 6, 32'h66); settle();
      chk("t5_wait", 64'(o_stall), 0);
      tick(); lu(0, 0, 0); i_issue_valid = 1; i_issue_reg = 6; settle();
      wb("t5_pop", 1, 6, 32'h66);
      tick(); i_issue_valid = 0; i_rd_reg2 = 6; settle();
      chk("t5_setwins", 64'(o_stall), 1);
      i_rd_reg2 = 0; i_dst_reg = 6; settle();
      chk("t5_waw", 64'(o_stall), 1);
      i_dst_reg = 0;
      // 6: async reset with buffered results and pending r9
      tick(); pipe(1, 3, 32'h11); i_issue_valid = 1; i_issue_reg = 9; lu(1, 6, 32'h1);
      tick(); i_issue_valid = 0; lu(1, 9, 32'h2);
      tick(); lu(0, 0, 0); i_rd_reg1 = 9; settle();
      chk("t6_full", 64'(o_lu_ready), 0);
      chk("t6_pend", 64'(o_stall), 1);
      pipe(0, 0, 0); i_rst_n = 0; #1;
      chk("t6_rst_ready", 64'(o_lu_ready), 1);
      chk("t6_rst_stall", 64'(o_stall), 0);
      wb("t6_rst_we", 0, 0, 0);
      tick(); tick(); i_rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         tick(); settle();
         wb("t6_post_we", 0, 0, 0);
         chk("t6_post_stall", 64'(o_stall), 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n, errs);
      $finish;
   end
endmodule
